// File: rtl/uart_tx.sv
// uart_tx: UART transmitter serialising one DATA_WIDTH-bit frame per Data_Valid strobe.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   P_DATA     parallel data, latched on accept
//   Data_Valid one-cycle transmit request, honoured only when idle
//   Par_En     1 = append a parity bit (latched on accept)
//   Par_Typ    0 = even, 1 = odd parity (latched on accept)
//   Prescale   clk cycles per bit, 0 treated as 1 (latched on accept)
//   TX_OUT     registered serial line, idles high
//   Busy       registered, high while a frame is in flight
//
// Build option: define UART_TX_TWO_STOP_EN for two stop bits per frame.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [5:0]            presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop2_q, stop2_d;
`endif
    logic                  last;

    assign last   = cnt_q == presc_q - 6'd1;
    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d   = stop2_q;
`endif
        cnt_d     = (state_q == IDLE || last) ? 6'd0 : cnt_q + 6'd1;
        case (state_q)
            IDLE: if (Data_Valid) begin
                state_d   = START;
                data_d    = P_DATA;
                par_en_d  = Par_En;
                par_bit_d = (^P_DATA) ^ Par_Typ;
                presc_d   = (Prescale == 6'd0) ? 6'd1 : Prescale;
                tx_d      = 1'b0;
                busy_d    = 1'b1;
            end
            START: if (last) begin
                state_d = DATA;
                idx_d   = '0;
                tx_d    = data_q[0];
            end
            DATA: if (last) begin
                if (idx_q == IW'(DATA_WIDTH - 1)) begin
                    state_d = par_en_q ? PARITY : STOP;
                    tx_d    = par_en_q ? par_bit_q : 1'b1;
                end else begin
                    // Shift register keeps the current bit at index 0.
                    idx_d  = idx_q + IW'(1);
                    data_d = data_q >> 1;
                    tx_d   = data_d[0];
                end
            end
            PARITY: if (last) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: if (last) begin
`ifdef UART_TX_TWO_STOP_EN
                // First pass through STOP only arms the second stop bit.
                stop2_d = ~stop2_q;
                state_d = stop2_q ? IDLE : STOP;
                busy_d  = ~stop2_q;
`else
                state_d = IDLE;
                busy_d  = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= stop2_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx, checking TX_OUT and Busy every cycle.
module tb_uart_tx;
    logic       clk, rst;
    logic [7:0] P_DATA;
    logic       Data_Valid, Par_En, Par_Typ;
    logic [5:0] Prescale;
    logic       TX_OUT, Busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         n;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic in_frame = 1'b0;
    exp_t cur;
    logic seq[0:15];
    int   nbits, idx;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .Par_En(Par_En), .Par_Typ(Par_Typ), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .Busy(Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int n, input logic pe);
        int bits = 10 + (pe ? 1 : 0);
`ifdef UART_TX_TWO_STOP_EN
        bits++;
`endif
        return bits * n;
    endfunction

    // Monitor: every cycle is checked against the frame popped at its start bit.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else if (!in_frame && TX_OUT !== 1'b0) begin
            check("idle_busy", 32'(Busy), 32'd0);
        end else begin
            if (!in_frame) begin
                check("start_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    seq[0] = 1'b0;
                    for (int i = 0; i < 8; i++) seq[1 + i] = cur.d[i];
                    nbits = 9;
                    if (cur.pe) begin
                        seq[nbits] = (^cur.d) ^ cur.pt;
                        nbits++;
                    end
                    seq[nbits] = 1'b1;
                    nbits++;
`ifdef UART_TX_TWO_STOP_EN
                    seq[nbits] = 1'b1;
                    nbits++;
`endif
                    in_frame = 1'b1;
                    idx = 0;
                end
            end
            if (in_frame) begin
                check("tx_bit", 32'(TX_OUT), 32'(seq[idx / cur.n]));
                check("frame_busy", 32'(Busy), 32'd1);
                idx++;
                if (idx == nbits * cur.n) in_frame = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
        @(negedge clk);
        P_DATA = d; Par_En = pe; Par_Typ = pt; Prescale = p; Data_Valid = 1'b1;
        sb.push_back('{d, pe, pt, (p == 6'd0) ? 1 : int'(p)});
        @(negedge clk);
        // Scramble all inputs mid-frame; the frame must not change.
        Data_Valid = 1'b0; P_DATA = ~d; Par_En = ~pe; Par_Typ = ~pt; Prescale = 6'($urandom);
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while ((sb.size() != 0 || in_frame) && k < max) begin
            @(posedge clk);
            k++;
        end
        check("done_timeout", 32'(k >= max), 32'd0);
    endtask

    initial begin
        int rem;
        rst = 1'b1; P_DATA = '0; Data_Valid = 1'b0; Par_En = 1'b0; Par_Typ = 1'b0; Prescale = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(TX_OUT), 32'd1);
        check("reset_busy", 32'(Busy), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(posedge clk);

        send(8'hA5, 1'b1, 1'b0, 6'd8);   wait_done(2000);
        send(8'h01, 1'b1, 1'b1, 6'd16);  wait_done(2000);
        send(8'hFF, 1'b0, 1'b1, 6'd16);  wait_done(2000);
        send(8'h5A, 1'b0, 1'b0, 6'd0);   wait_done(2000);
        send(8'hC3, 1'b1, 1'b1, 6'd63);  wait_done(2000);
        send(8'h3C, 1'b0, 1'b0, 6'd8);   wait_done(2000);

        // Mid-frame strobe must be dropped.
        send(8'h96, 1'b1, 1'b0, 6'd4);
        repeat (6) @(negedge clk);
        P_DATA = 8'h00; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        wait_done(2000);

        // Data_Valid held high: one accept per frame plus one idle cycle.
        rem = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            P_DATA = 8'($urandom); Data_Valid = 1'b1; Par_En = 1'b1; Par_Typ = c[0]; Prescale = 6'd2;
            if (rem == 0) begin
                sb.push_back('{P_DATA, 1'b1, Par_Typ, 2});
                rem = frame_len(2, 1'b1);
            end else begin
                rem--;
            end
        end
        @(negedge clk);
        Data_Valid = 1'b0;
        wait_done(2000);

        // Asynchronous reset mid-frame abandons the frame immediately.
        send(8'hE7, 1'b1, 1'b0, 6'd5);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_tx", 32'(TX_OUT), 32'd1);
        check("midreset_busy", 32'(Busy), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (8) @(posedge clk);
        send(8'h81, 1'b1, 1'b1, 6'd3);   wait_done(2000);
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: the transmit-side counterpart of the UART receiver, sharing the same frame format, parity options and Prescale port.
- Accepts a parallel byte with a one-cycle valid strobe and serialises it LSB-first on TX_OUT: start bit, DATA_WIDTH data bits, optional parity bit, stop bit.
- Each bit is held for Prescale clk cycles.
- Sits between the system's TX FIFO/controller and the serial pin; Busy gates the upstream pop.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel data to send; sampled only on accept.
- Data_Valid  input  1  one-cycle strobe requesting transmission of P_DATA.
- Par_En  input  1  1 = insert parity bit; sampled on accept.
- Par_Typ  input  1  0 = even, 1 = odd; sampled on accept.
- Prescale  input  6  clk cycles per bit; sampled on accept.
- TX_OUT  output  1  serial line, registered, idles high.
- Busy  output  1  high while a frame is in flight, registered.

Behaviour:
- Reset (asynchronous, any state): TX_OUT=1, Busy=0, FSM=IDLE, all counters and holding registers 0. Applies immediately mid-frame; the partial frame is abandoned.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: Data_Valid=1 while FSM=IDLE latches P_DATA, Par_En, Par_Typ and Prescale (value 0 latched as 1).
  - Parity bit is computed at accept: even = XOR of data bits; odd = inverted XOR.
  - Data_Valid outside IDLE is ignored; no queueing, no error flag.
- Latency: Data_Valid at edge k gives TX_OUT=0 and Busy=1 from the cycle after edge k.
- Bit timing: a 6-bit cycle counter runs 0..N-1 (N = latched Prescale). The state and bit index advance when the counter equals N-1, and the counter then wraps to 0.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA after N cycles.
  - DATA: bit index 0..DATA_WIDTH-1, TX_OUT = data[index]. After bit DATA_WIDTH-1 completes: -> PARITY if Par_En, else -> STOP.
  - PARITY: TX_OUT = parity bit for N cycles, then -> STOP.
  - STOP: TX_OUT=1 for N cycles, then -> IDLE.
- Frame length: (DATA_WIDTH + 2 + Par_En) x N cycles.
- Busy is high in every non-IDLE state and falls in the first IDLE cycle.
- Back-to-back frames: a Data_Valid in the first IDLE cycle is accepted. The minimum inter-frame gap is therefore 1 clk of idle-high.
- Changes to P_DATA, Par_En, Par_Typ or Prescale mid-frame have no effect on the current frame.
- TX_OUT is driven directly from a flop; no glitches.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2N cycles (two stop bits), and frame length gains N cycles.
- Undefined: single stop bit, as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset/idle: assert rst mid-frame -> TX_OUT=1 and Busy=0 in the same cycle; no activity until the next Data_Valid.
- Even parity: Prescale=8, Par_En=1, Par_Typ=0, P_DATA=0xA5, one-cycle Data_Valid -> TX_OUT sequence 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit 8 cycles. Busy high for exactly 88 cycles.
- Odd parity and no parity:
  - Prescale=16, Par_Typ=1, P_DATA=0x01 -> parity bit 0.
  - Repeat with Par_En=0, P_DATA=0xFF -> no parity slot; frame = 160 cycles.
- Busy/back-to-back:
  - Hold Data_Valid high continuously with P_DATA changing each cycle -> frames separated by exactly one idle-high cycle.
  - Each frame carries the byte present in its accept cycle; mid-frame strobes are dropped.
- Prescale edge cases:
  - Prescale=0 -> behaves as 1 (10 cycles/frame, no parity).
  - Prescale=63 -> 63 cycles/bit.
  - Changing Prescale mid-frame -> no effect until the next frame.
- With UART_TX_TWO_STOP_EN: Prescale=8, Par_En=0, P_DATA=0x3C -> stop high for 16 cycles; Busy high for 88 cycles.
